// File: rtl/wisc_pkg.sv
// WISC instruction-set constants and the field-packing function shared by the encoder.
package wisc_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned OFF_W   = 6;
  localparam int unsigned IMM_W   = 8;

  localparam logic [OP_W-1:0] OpVadd = 4'b0000;
  localparam logic [OP_W-1:0] OpVdot = 4'b0001;
  localparam logic [OP_W-1:0] OpSmul = 4'b0010;
  localparam logic [OP_W-1:0] OpSst  = 4'b0011;
  localparam logic [OP_W-1:0] OpVld  = 4'b0100;
  localparam logic [OP_W-1:0] OpVst  = 4'b0101;
  localparam logic [OP_W-1:0] OpSll  = 4'b0110;
  localparam logic [OP_W-1:0] OpSlh  = 4'b0111;
  localparam logic [OP_W-1:0] OpJ    = 4'b1000;
  localparam logic [OP_W-1:0] OpNop  = 4'b1111;

  typedef enum logic [1:0] {StLoad, StDrain, StDone} enc_state_e;

  // Only the fields an opcode uses reach the word; everything else is forced to zero.
  function automatic logic [INSTR_W-1:0] encode(input logic [OP_W-1:0]  op,
                                                input logic [REG_W-1:0] dst,
                                                input logic [REG_W-1:0] src1,
                                                input logic [REG_W-1:0] src2,
                                                input logic [OFF_W-1:0] offset,
                                                input logic [IMM_W-1:0] imm);
    logic [INSTR_W-1:0] word;
    case (op)
      OpVadd, OpVdot, OpSmul: word = {op, dst, src1, src2, 3'b000};
      OpVld:                  word = {op, dst, src1, offset};
      OpVst, OpSst:           word = {op, src2, src1, offset};
      OpSll, OpSlh:           word = {op, dst, 1'b0, imm};
      OpJ:                    word = {op, 4'b0000, imm};
      default:                word = {op, 12'h000};
    endcase
    return word;
  endfunction

  // Opcodes 1001..1110 have no defined instruction.
  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return (op >= 4'b1001) && (op <= 4'b1110);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy level; storage is flushed by reset.
module sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == (PTR_W+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Storage, pointers (wrap relies on power-of-2 depth) and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs field bundles into 16-bit WISC words, buffers them and streams them with
// sequential addresses. Define INSTR_CHECK_EN to drop illegal opcodes and flag them.
module instr_encoder
  import wisc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_functype,
  input  logic [2:0]        in_dst,
  input  logic [2:0]        in_src1,
  input  logic [2:0]        in_src2,
  input  logic [5:0]        in_offset,
  input  logic [7:0]        in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              done,
  output logic              err_illegal
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  enc_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic [16:0]       fifo_rdata;
  logic [PTR_W:0]    fifo_level;
  logic              fifo_full, fifo_empty;
  logic              accept, drop, push, pop, drains_now;

  assign in_ready = (state_q == StLoad) && (fifo_level != (PTR_W+1)'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && !drop && !fifo_full;
  assign pop      = out_valid && out_ready;
  // FIFO is (or becomes this cycle) empty, so a dropped final bundle finishes the program.
  assign drains_now = fifo_empty || ((fifo_level == (PTR_W+1)'(1)) && pop);

`ifdef INSTR_CHECK_EN
  logic err_q;
  assign drop        = is_illegal(in_functype);
  assign err_illegal = err_q;

  // Sticky flag for any accepted bundle carrying an undefined opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    err_q <= 1'b0;
    else if (accept && drop)    err_q <= 1'b1;
  end
`else
  assign drop        = 1'b0;
  assign err_illegal = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (17),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_last, encode(in_functype, in_dst, in_src1, in_src2, in_offset, in_imm)}),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stale storage is masked so idle outputs read as zero.
  assign out_valid = !fifo_empty;
  assign out_instr = fifo_empty ? 16'h0000 : fifo_rdata[15:0];
  assign out_last  = !fifo_empty && fifo_rdata[16];
  assign out_addr  = addr_q;
  assign done      = done_q;

  // Program-level FSM: load bundles, drain after the final one, then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StLoad;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StLoad: begin
          if (accept && in_last) begin
            if (drop && drains_now) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pop && out_last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone:  state_q <= StDone;
        default: state_q <= StLoad;
      endcase
    end
  end

  // Target address advances once per word taken by the writer, wrapping silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      addr_q <= ADDR_W'(BASE_ADDR);
    else if (pop) addr_q <= addr_q + 1'b1;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table of encodings, scoreboard of expected words,
// backpressure, address wrap (second instance with ADDR_W=2), illegal opcode, async reset.
module tb_instr_encoder;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  dst;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [5:0]  off;
    logic [7:0]  imm;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_functype = '0;
  logic [2:0]  in_dst = '0, in_src1 = '0, in_src2 = '0;
  logic [5:0]  in_offset = '0;
  logic [7:0]  in_imm = '0;
  logic        in_ready, out_valid, out_last, done, err_illegal;
  logic [15:0] out_instr;
  logic [7:0]  out_addr;
  logic        in_ready2, out_valid2, out_last2, done2, err_illegal2;
  logic [15:0] out_instr2;
  logic [1:0]  out_addr2;

  exp_t        sb[$];
  logic [7:0]  exp_addr = '0;
  int          n_vec = 0;
  int          n_bad = 0;
  vec_t        tbl[10];
  vec_t        v;
  bit          acc;

  always #5 clk = ~clk;

  instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_functype(in_functype), .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
    .in_offset(in_offset), .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_last(out_last), .done(done), .err_illegal(err_illegal)
  );

  instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_functype(in_functype), .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
    .in_offset(in_offset), .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_addr(out_addr2), .out_last(out_last2), .done(done2), .err_illegal(err_illegal2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: compare the head entry whenever a word is presented, retire it on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", out_instr, $time);
      end else begin
        check("instr", out_instr, sb[0].instr);
        check("addr", out_addr, exp_addr);
        check("last", out_last, sb[0].last);
        check("w2_valid", out_valid2, 1);
        check("w2_instr", out_instr2, sb[0].instr);
        check("w2_addr", out_addr2, exp_addr[1:0]);
        if (out_ready) begin
          void'(sb.pop_front());
          exp_addr = exp_addr + 8'd1;
        end
      end
    end
  end

  task automatic send(input vec_t vv, input logic last, input bit push_exp, input int budget,
                      output bit accepted);
    exp_t e;
    in_functype = vv.op; in_dst = vv.dst; in_src1 = vv.s1; in_src2 = vv.s2;
    in_offset = vv.off;  in_imm = vv.imm; in_last = last; in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < budget && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (accepted && push_exp) begin
      e.instr = vv.exp;
      e.last  = last;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    check("done", done, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_done", done, 0);
    check("rst_err", err_illegal, 0);
    sb.delete();
    exp_addr = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    // Ignored fields are driven to all ones to catch leakage.
    tbl[0] = '{4'h0, 3'd3, 3'd5, 3'd2, 6'h3F, 8'hFF, 16'h0750};  // VADD
    tbl[1] = '{4'h1, 3'd1, 3'd2, 3'd3, 6'h3F, 8'hFF, 16'h1298};  // VDOT
    tbl[2] = '{4'h2, 3'd7, 3'd0, 3'd7, 6'h3F, 8'hFF, 16'h2E38};  // SMUL
    tbl[3] = '{4'h4, 3'd1, 3'd2, 3'd7, 6'h2A, 8'hFF, 16'h42AA};  // VLD
    tbl[4] = '{4'h5, 3'd7, 3'd1, 3'd6, 6'h05, 8'hFF, 16'h5C45};  // VST
    tbl[5] = '{4'h3, 3'd7, 3'd3, 3'd2, 6'h3F, 8'hFF, 16'h34FF};  // SST
    tbl[6] = '{4'h6, 3'd4, 3'd7, 3'd7, 6'h3F, 8'hC3, 16'h68C3};  // SLL
    tbl[7] = '{4'h7, 3'd2, 3'd7, 3'd7, 6'h3F, 8'h5A, 16'h745A};  // SLH
    tbl[8] = '{4'h8, 3'd7, 3'd7, 3'd7, 6'h3F, 8'h81, 16'h8081};  // J
    tbl[9] = '{4'hF, 3'd7, 3'd7, 3'd7, 6'h3F, 8'hFF, 16'hF000};  // NOP

    do_reset();

    // Every opcode once as a 10-word program; ADDR_W=2 instance wraps 0..3,0..3,0,1.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i], (i == 9), 1'b1, 50, acc);
      check("accept_tbl", acc, 1);
      if (i == 0) check("latency_valid", out_valid, 1);
    end
    wait_done(100);
    check("done_in_ready", in_ready, 0);
    check("sb_drained", sb.size(), 0);

    // Backpressure: four words fill the buffer, fifth is held off until the writer drains.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(tbl[i], 1'b0, 1'b1, 10, acc);
      check("accept_fill", acc, 1);
    end
    check("full_in_ready", in_ready, 0);
    send(tbl[4], 1'b1, 1'b1, 3, acc);
    check("fifth_blocked", acc, 0);
    out_ready = 1'b1;
    send(tbl[4], 1'b1, 1'b1, 20, acc);
    check("fifth_accepted", acc, 1);
    wait_done(100);
    check("bp_drained", sb.size(), 0);

    // Illegal opcode 1010 as the program's only (last) bundle.
    do_reset();
    v = '{4'hA, 3'd7, 3'd7, 3'd7, 6'h3F, 8'hFF, 16'hA000};
`ifdef INSTR_CHECK_EN
    send(v, 1'b1, 1'b0, 20, acc);
    check("illegal_accepted", acc, 1);
    wait_done(50);
    check("err_illegal", err_illegal, 1);
`else
    send(v, 1'b1, 1'b1, 20, acc);
    check("illegal_accepted", acc, 1);
    wait_done(50);
    check("err_illegal", err_illegal, 0);
`endif
    check("illegal_drained", sb.size(), 0);

    // Asynchronous reset with three words queued.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(tbl[i + 5], 1'b0, 1'b1, 10, acc);
      check("accept_pre_rst", acc, 1);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_addr", out_addr, 0);
    check("midrst_done", done, 0);
    check("midrst_out_instr", out_instr, 0);
    do_reset();
    check("post_rst_out_valid", out_valid, 0);

    // Short program after reset: VLD then SLL (last) from address 0.
    out_ready = 1'b1;
    send(tbl[3], 1'b0, 1'b1, 10, acc);
    check("accept_vld", acc, 1);
    send(tbl[6], 1'b1, 1'b1, 10, acc);
    check("accept_sll", acc, 1);
    wait_done(50);
    check("final_drained", sb.size(), 0);
    repeat (2) @(negedge clk);
    check("done_sticky", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
